axis_hex_ascii_tx: RTL and testbench

AXI4-Stream sink that consumes 32-bit sample words, such as the transaction-count samples, and turns each word into a line of ASCII hex characters. Each line is NIBBLES hex digits, MSB digit first, optionally followed by CR LF. Characters leave on an 8-bit AXI4-Stream master that feeds the UART transmitter. Sits between 32-bit stream producers and the byte-wide UART TX path. It applies backpressure upstream while a line is being sent.

---
 rtl/axis_hex_pkg.sv | 20 ++
 rtl/hex_nibble_to_ascii.sv | 26 ++
 rtl/axis_hex_ascii_tx.sv | 161 ++++++++++++++++
 tb/tb_axis_hex_ascii_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/axis_hex_pkg.sv
// Shared definitions for the AXI4-Stream word-to-ASCII-hex line transmitter.
// Contents:
//   state_t            - line transmitter FSM states
//   ASCII_* constants  - character codes used for digits and line endings
package axis_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_A_LC = 8'h61;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational hex digit encoder: one 4-bit nibble to its ASCII character.
// Ports:
//   nibble_i - value 0..15
//   char_o   - '0'..'9' or 'A'..'F' / 'a'..'f' depending on UPPERCASE
module hex_nibble_to_ascii
  import axis_hex_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] nibble_i,
  output logic [7:0] char_o
);

  localparam logic [7:0] ALPHA_BASE = UPPERCASE ? ASCII_A_UC : ASCII_A_LC;

  // Map decimal digits onto '0' and the letters onto the selected alphabet case.
  always_comb begin
    char_o = 8'h00;
    if (nibble_i < 4'd10) begin
      char_o = ASCII_0 + {4'b0000, nibble_i};
    end else begin
      char_o = ALPHA_BASE + ({4'b0000, nibble_i} - 8'd10);
    end
  end

endmodule

// File: rtl/axis_hex_ascii_tx.sv
// Converts each accepted 32-bit stream word into a line of ASCII hex digits
// (most significant of the lowest NIBBLES digits first), optionally followed
// by CR LF, and sends it one character per handshake on a byte stream.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-low reset
//   s_axis_*        - 32-bit word sink; tready is low while a line is in flight
//   m_axis_*        - 8-bit character source toward the UART transmitter
//   busy            - high from word accept until the final character handshake
module axis_hex_ascii_tx
  import axis_hex_pkg::*;
#(
  parameter int NIBBLES   = 8,
  parameter bit EOL_CRLF  = 1'b1,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy
);

  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        sready_q, sready_d;
  logic        busy_q, busy_d;

  logic        m_hs_s;
  logic [2:0]  idx_dec_s;
  logic [3:0]  nib_s;
  logic [7:0]  char_s;

  assign m_hs_s    = tvalid_q & m_axis_tready;
  assign idx_dec_s = idx_q - 3'd1;

  // One encoder serves both the first digit (from the incoming word at accept)
  // and every following digit (from the captured word).
  always_comb begin
    nib_s = 4'h0;
    if (state_q == IDLE) begin
      nib_s = s_axis_tdata[4*(NIBBLES-1) +: 4];
    end else begin
      nib_s = word_q[{idx_dec_s, 2'b00} +: 4];
    end
  end

  hex_nibble_to_ascii #(
    .UPPERCASE (UPPERCASE)
  ) u_enc (
    .nibble_i (nib_s),
    .char_o   (char_s)
  );

  // Next-state and registered-output computation for the line transmitter.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    sready_d = sready_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        sready_d = 1'b1;
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
        if (s_axis_tvalid && sready_q) begin
          word_d   = s_axis_tdata;
          idx_d    = LAST_IDX;
          tdata_d  = char_s;
          tvalid_d = 1'b1;
          sready_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = DIGIT;
        end else begin
          state_d = IDLE;
        end
      end
      DIGIT: begin
        if (m_hs_s) begin
          if (idx_q != 3'd0) begin
            idx_d   = idx_dec_s;
            tdata_d = char_s;
          end else if (EOL_CRLF) begin
            tdata_d = ASCII_CR;
            state_d = CR;
          end else begin
            // Last digit gone and no line ending: reopen the sink now.
            tvalid_d = 1'b0;
            busy_d   = 1'b0;
            sready_d = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          state_d = DIGIT;
        end
      end
      CR: begin
        if (m_hs_s) begin
          tdata_d = ASCII_LF;
          state_d = LF;
        end else begin
          state_d = CR;
        end
      end
      LF: begin
        if (m_hs_s) begin
          tvalid_d = 1'b0;
          busy_d   = 1'b0;
          sready_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = LF;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
        sready_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partially sent line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      word_q   <= 32'h0000_0000;
      idx_q    <= 3'd0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      sready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      sready_q <= sready_d;
      busy_q   <= busy_d;
    end
  end

  assign s_axis_tready = sready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_hex_ascii_tx.sv
// Directed bench for axis_hex_ascii_tx: three instances cover the default
// configuration, lowercase digits, and a 4-digit line without CR LF.
module tb_axis_hex_ascii_tx;

  logic clk;
  logic reset;

  logic [31:0] drv_s_tdata;
  logic        drv_s_tvalid;
  logic        drv_m_tready;
  int          sel;

  logic [31:0] s_tdata [3];
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic [7:0]  m_tdata [3];
  logic        m_tvalid [3];
  logic        m_tready [3];
  logic        busy_o [3];

  logic [7:0] mon_tdata;
  logic       mon_tvalid;
  logic       mon_sready;
  logic       mon_busy;

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the single driver to the selected instance; others stay idle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      s_tdata[i]  = drv_s_tdata;
      s_tvalid[i] = drv_s_tvalid && (sel == i);
      m_tready[i] = (sel == i) ? drv_m_tready : 1'b1;
    end
    mon_tdata  = m_tdata[sel];
    mon_tvalid = m_tvalid[sel];
    mon_sready = s_tready[sel];
    mon_busy   = busy_o[sel];
  end

  axis_hex_ascii_tx dut (
    .clk (clk), .reset (reset),
    .s_axis_tdata (s_tdata[0]), .s_axis_tvalid (s_tvalid[0]), .s_axis_tready (s_tready[0]),
    .m_axis_tdata (m_tdata[0]), .m_axis_tvalid (m_tvalid[0]), .m_axis_tready (m_tready[0]),
    .busy (busy_o[0])
  );

  axis_hex_ascii_tx #(.NIBBLES(8), .EOL_CRLF(1'b1), .UPPERCASE(1'b0)) dut_lc (
    .clk (clk), .reset (reset),
    .s_axis_tdata (s_tdata[1]), .s_axis_tvalid (s_tvalid[1]), .s_axis_tready (s_tready[1]),
    .m_axis_tdata (m_tdata[1]), .m_axis_tvalid (m_tvalid[1]), .m_axis_tready (m_tready[1]),
    .busy (busy_o[1])
  );

  axis_hex_ascii_tx #(.NIBBLES(4), .EOL_CRLF(1'b0), .UPPERCASE(1'b1)) dut_n4 (
    .clk (clk), .reset (reset),
    .s_axis_tdata (s_tdata[2]), .s_axis_tvalid (s_tvalid[2]), .s_axis_tready (s_tready[2]),
    .m_axis_tdata (m_tdata[2]), .m_axis_tvalid (m_tvalid[2]), .m_axis_tready (m_tready[2]),
    .busy (busy_o[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge with the sink idle; the accept happens on the next posedge.
  task automatic present(input logic [31:0] w);
    drv_s_tdata  = w;
    drv_s_tvalid = 1'b1;
    chk("accept_sready", {31'd0, mon_sready}, 32'd1);
    @(negedge clk);
    drv_s_tvalid = 1'b0;
  endtask

  // Receive the expected characters one per cycle, optionally stalling tready
  // for stall_len cycles while character stall_at is pending.
  task automatic recv(input string exp, input int stall_at, input int stall_len, input bit full);
    int k;
    int cyc;
    int st;
    logic [7:0] e;
    k = 0; cyc = 0; st = 0;
    while (k < exp.len() && cyc < 100) begin
      e = exp[k];
      if (k == stall_at && st < stall_len) begin
        drv_m_tready = 1'b0;
        st++;
        chk("stall_tvalid", {31'd0, mon_tvalid}, 32'd1);
        chk("stall_tdata", {24'd0, mon_tdata}, {24'd0, e});
      end else begin
        drv_m_tready = 1'b1;
        chk("char_tvalid", {31'd0, mon_tvalid}, 32'd1);
        chk("char_tdata", {24'd0, mon_tdata}, {24'd0, e});
        chk("line_busy", {31'd0, mon_busy}, 32'd1);
        chk("line_sready", {31'd0, mon_sready}, 32'd0);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) chk("line_timeout", k, exp.len());
    if (full) begin
      chk("end_tvalid", {31'd0, mon_tvalid}, 32'd0);
      chk("end_sready", {31'd0, mon_sready}, 32'd1);
      chk("end_busy", {31'd0, mon_busy}, 32'd0);
    end
    drv_m_tready = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    sel = 0;
    reset = 1'b0;
    drv_s_tdata = 32'h0;
    drv_s_tvalid = 1'b0;
    drv_m_tready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_tvalid", {31'd0, mon_tvalid}, 32'd0);
    chk("rst_sready", {31'd0, mon_sready}, 32'd0);
    chk("rst_busy", {31'd0, mon_busy}, 32'd0);
    chk("rst_tdata", {24'd0, mon_tdata}, 32'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_sready", {31'd0, mon_sready}, 32'd1);

    // 1: basic line
    present(32'h0000_1234);
    recv("00001234\r\n", -1, 0, 1'b1);

    // 2: letters, both cases
    present(32'hDEAD_BEEF);
    recv("DEADBEEF\r\n", -1, 0, 1'b1);
    sel = 1;
    present(32'hDEAD_BEEF);
    recv("deadbeef\r\n", -1, 0, 1'b1);
    sel = 0;

    // 3: stall for 5 cycles on the third character
    present(32'h0000_0000);
    recv("00000000\r\n", 2, 5, 1'b1);

    // 4: back-to-back words with tvalid held
    present(32'h0000_0001);
    drv_s_tdata  = 32'hFFFF_FFFF;
    drv_s_tvalid = 1'b1;
    recv("00000001\r\n", -1, 0, 1'b1);
    present(32'hFFFF_FFFF);
    recv("FFFFFFFF\r\n", -1, 0, 1'b1);

    // 5: asynchronous reset mid-line
    present(32'h1234_5678);
    recv("1234", -1, 0, 1'b0);
    chk("pre_rst_tvalid", {31'd0, mon_tvalid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_tvalid", {31'd0, mon_tvalid}, 32'd0);
    chk("async_rst_busy", {31'd0, mon_busy}, 32'd0);
    chk("async_rst_sready", {31'd0, mon_sready}, 32'd0);
    chk("async_rst_tdata", {24'd0, mon_tdata}, 32'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rerst_sready", {31'd0, mon_sready}, 32'd1);
    chk("rerst_tvalid", {31'd0, mon_tvalid}, 32'd0);
    present(32'h0000_00AB);
    recv("000000AB\r\n", -1, 0, 1'b1);

    // 6: four digits, no line ending; sink ready again at cycle 5
    sel = 2;
    @(negedge clk);
    present(32'hABCD_1234);
    recv("1234", -1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
